// File: rtl/points_sequencer.sv
// rtl/points_sequencer.sv - turns brick-hit point values into SCLOCK-paced score pulses routed to one player
// Optional per-player 10-bit score totals: define POINTS_SEQUENCER_TOTAL_EN.
module points_sequencer #(
    parameter int NUM_PLAYERS = 2,
    parameter int VALUE_W     = 3,
    parameter int PEND_W      = 6,
    parameter int HOLDOFF     = 6,
    localparam int SEL_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   CLK_DRV,
    input  logic                   RESET,
    input  logic                   START_GAME,
    input  logic                   ATTRACT_N,
    input  logic                   BRICK_HIT,
    input  logic [VALUE_W-1:0]     HIT_VALUE,
    input  logic [SEL_W-1:0]       PLAYER_SEL,
    input  logic                   SCLOCK,
    output logic                   COUNT,
    output logic [NUM_PLAYERS-1:0] COUNT_P,
    output logic                   BUSY,
    output logic [PEND_W-1:0]      PENDING
`ifdef POINTS_SEQUENCER_TOTAL_EN
    ,
    output logic [NUM_PLAYERS*10-1:0] SCORE_TOTAL
`endif
);

    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int SUM_W  = ((PEND_W > VALUE_W) ? PEND_W : VALUE_W) + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t                   r_state;
    logic                     r_prev_hit;
    logic [HOLD_W-1:0]        r_holdoff;
    logic [PEND_W-1:0]        r_pending;
    logic                     r_busy;
    logic                     r_count;
    logic [NUM_PLAYERS-1:0]   r_count_p;
    logic [SEL_W-1:0]         r_player;

    logic                     w_event;
    logic                     w_accept;
    logic                     w_pulse;
    logic [VALUE_W-1:0]       w_add;
    logic [SUM_W-1:0]         w_sum;
    logic [PEND_W-1:0]        w_pend_next;
    logic [SEL_W-1:0]         w_sel;
    logic [NUM_PLAYERS-1:0]   w_player_oh;

    assign w_event  = BRICK_HIT & ~r_prev_hit;
    assign w_accept = w_event & (r_holdoff == '0) & ATTRACT_N;
    // A strobe coinciding with the first hit sees PENDING still zero, so no pulse yet.
    assign w_pulse  = SCLOCK & (r_pending != '0) & ATTRACT_N;
    assign w_add    = w_accept ? HIT_VALUE : '0;
    assign w_sel    = (int'(PLAYER_SEL) < NUM_PLAYERS) ? PLAYER_SEL : '0;

    always_comb begin
        w_sum = SUM_W'(r_pending) + SUM_W'(w_add) - SUM_W'(w_pulse);
        if (w_sum > SUM_W'(PEND_MAX)) begin
            w_pend_next = PEND_MAX;
        end else begin
            w_pend_next = w_sum[PEND_W-1:0];
        end
    end

    always_comb begin
        w_player_oh = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (int'(r_player) == p) begin
                w_player_oh[p] = 1'b1;
            end
        end
    end

    // The burst player is captured only on IDLE->BURST, so mid-burst hits extend the same player's train.
    always_ff @(posedge CLK_DRV) begin
        r_prev_hit <= BRICK_HIT;
        if (RESET || START_GAME) begin
            r_prev_hit <= 1'b0;
            r_state    <= S_IDLE;
            r_holdoff  <= '0;
            r_pending  <= '0;
            r_busy     <= 1'b0;
            r_count    <= 1'b0;
            r_count_p  <= '0;
            r_player   <= '0;
        end else if (!ATTRACT_N) begin
            r_state    <= S_IDLE;
            r_holdoff  <= '0;
            r_pending  <= '0;
            r_busy     <= 1'b0;
            r_count    <= 1'b0;
            r_count_p  <= '0;
        end else begin
            r_pending <= w_pend_next;
            r_busy    <= (w_pend_next != '0);
            r_count   <= w_pulse;
            r_count_p <= w_pulse ? w_player_oh : '0;

            if (w_accept) begin
                r_holdoff <= HOLD_W'(HOLDOFF);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - HOLD_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pend_next != '0) begin
                        r_state  <= S_BURST;
                        r_player <= w_sel;
                    end
                end
                S_BURST: begin
                    if (w_pend_next == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign COUNT   = r_count;
    assign COUNT_P = r_count_p;
    assign BUSY    = r_busy;
    assign PENDING = r_pending;

`ifdef POINTS_SEQUENCER_TOTAL_EN
    // Totals survive attract mode; only a reset or new game clears them.
    logic [9:0] r_total [NUM_PLAYERS];

    always_ff @(posedge CLK_DRV) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (RESET || START_GAME) begin
                r_total[p] <= 10'd0;
            end else if (r_count_p[p]) begin
                r_total[p] <= r_total[p] + 10'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_total
        assign SCORE_TOTAL[10*g +: 10] = r_total[g];
    end
`endif

endmodule

// File: tb/tb_points_sequencer.sv
// tb/tb_points_sequencer.sv - scoreboard bench for points_sequencer (PEND_W=4, two players)
module tb_points_sequencer;

    logic       CLK_DRV = 1'b0;
    logic       RESET = 1'b1;
    logic       START_GAME = 1'b0;
    logic       ATTRACT_N = 1'b1;
    logic       BRICK_HIT = 1'b0;
    logic [2:0] HIT_VALUE = 3'd0;
    logic [0:0] PLAYER_SEL = 1'b0;
    logic       SCLOCK = 1'b0;
    logic       COUNT;
    logic [1:0] COUNT_P;
    logic       BUSY;
    logic [3:0] PENDING;
`ifdef POINTS_SEQUENCER_TOTAL_EN
    logic [19:0] SCORE_TOTAL;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int base;
    logic sclk_d = 1'b0;
    logic [1:0] exp_q[$];

    points_sequencer #(
        .NUM_PLAYERS(2),
        .VALUE_W(3),
        .PEND_W(4),
        .HOLDOFF(6)
    ) dut (
        .CLK_DRV(CLK_DRV),
        .RESET(RESET),
        .START_GAME(START_GAME),
        .ATTRACT_N(ATTRACT_N),
        .BRICK_HIT(BRICK_HIT),
        .HIT_VALUE(HIT_VALUE),
        .PLAYER_SEL(PLAYER_SEL),
        .SCLOCK(SCLOCK),
        .COUNT(COUNT),
        .COUNT_P(COUNT_P),
        .BUSY(BUSY),
        .PENDING(PENDING)
`ifdef POINTS_SEQUENCER_TOTAL_EN
        ,
        .SCORE_TOTAL(SCORE_TOTAL)
`endif
    );

    always #5 CLK_DRV = ~CLK_DRV;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_DRV);
        #1;
    endtask

    task automatic hit(input logic [2:0] v, input logic [0:0] sel, input logic s);
        BRICK_HIT  = 1'b1;
        HIT_VALUE  = v;
        PLAYER_SEL = sel;
        SCLOCK     = s;
        tick();
        BRICK_HIT = 1'b0;
        SCLOCK    = 1'b0;
    endtask

    task automatic push(input int n, input logic [1:0] oh);
        for (int i = 0; i < n; i++) exp_q.push_back(oh);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Strobe every 'period' cycles until the burst drains; BUSY must fall together with the last pulse.
    task automatic run_strobes(input int period, input int budget);
        int n;
        n = 0;
        while (BUSY && n < budget) begin
            SCLOCK = ((n % period) == 0);
            tick();
            n++;
            if (!BUSY) check("busy_falls_with_last_pulse", 32'(COUNT), 32'd1);
        end
        SCLOCK = 1'b0;
        if (BUSY) check("burst_timeout", 32'(BUSY), 32'd0);
    endtask

    // Monitor: each COUNT pulse pops one expected COUNT_P and must follow a strobe by one cycle.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge CLK_DRV);
            if (COUNT) begin
                pulses++;
                check("pulse_after_strobe", 32'(sclk_d), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(COUNT_P), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("count_p", 32'(COUNT_P), 32'(e));
                end
            end
            sclk_d = SCLOCK;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_n(2);
        RESET = 1'b0;
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_count_p", 32'(COUNT_P), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_pending", 32'(PENDING), 32'd0);

        // Basic burst: 4 points to player 1, strobe every 8 cycles.
        base = pulses;
        hit(3'd4, 1'b1, 1'b0);
        push(4, 2'b10);
        check("t1_pending", 32'(PENDING), 32'd4);
        check("t1_busy", 32'(BUSY), 32'd1);
        run_strobes(8, 100);
        tick();
        check("t1_pulses", 32'(pulses - base), 32'd4);

        // Holdoff: edge 3 cycles later ignored, 7 cycles later accepted.
        base = pulses;
        hit(3'd2, 1'b1, 1'b0);
        wait_n(2);
        hit(3'd5, 1'b1, 1'b0);
        check("t2_ignored", 32'(PENDING), 32'd2);
        wait_n(3);
        hit(3'd3, 1'b1, 1'b0);
        check("t2_accepted", 32'(PENDING), 32'd5);
        push(5, 2'b10);

        // Hit with coincident strobe: 5 + 3 - 1 = 7; PLAYER_SEL change must not reroute.
        wait_n(6);
        hit(3'd3, 1'b0, 1'b1);
        push(3, 2'b10);
        check("t3_pending", 32'(PENDING), 32'd7);
        run_strobes(3, 200);
        tick();
        check("t3_pulses", 32'(pulses - base), 32'd8);

        // Zero-value hit starts holdoff but adds nothing.
        wait_n(8);
        hit(3'd0, 1'b0, 1'b0);
        check("t0v_pending", 32'(PENDING), 32'd0);
        check("t0v_busy", 32'(BUSY), 32'd0);
        tick();
        hit(3'd5, 1'b0, 1'b0);
        check("t0v_holdoff", 32'(PENDING), 32'd0);
        wait_n(8);

        // Saturation at 15.
        base = pulses;
        hit(3'd7, 1'b0, 1'b0);
        wait_n(6);
        hit(3'd7, 1'b0, 1'b0);
        check("t4_pending14", 32'(PENDING), 32'd14);
        wait_n(6);
        hit(3'd7, 1'b0, 1'b0);
        check("t4_saturate", 32'(PENDING), 32'd15);
        push(15, 2'b10 >> 1);
        run_strobes(2, 200);
        tick();
        check("t4_pulses", 32'(pulses - base), 32'd15);

        // Attract mode mid-burst.
        wait_n(8);
        hit(3'd4, 1'b1, 1'b0);
        check("t5_pending4", 32'(PENDING), 32'd4);
        push(1, 2'b10);
        SCLOCK = 1'b1;
        tick();
        check("t5_pending3", 32'(PENDING), 32'd3);
        ATTRACT_N = 1'b0;
        tick();
        SCLOCK = 1'b0;
        check("t5_attr_pending", 32'(PENDING), 32'd0);
        check("t5_attr_busy", 32'(BUSY), 32'd0);
        check("t5_attr_count", 32'(COUNT), 32'd0);
        hit(3'd5, 1'b0, 1'b1);
        check("t5_attr_hit", 32'(PENDING), 32'd0);
        check("t5_attr_nopulse", 32'(COUNT), 32'd0);
        tick();
        ATTRACT_N = 1'b1;
        wait_n(8);

        // Reset mid-burst, then START_GAME clears pending.
        hit(3'd6, 1'b0, 1'b0);
        push(1, 2'b01);
        SCLOCK = 1'b1;
        tick();
        check("t6_pending5", 32'(PENDING), 32'd5);
        RESET = 1'b1;
        tick();
        RESET  = 1'b0;
        SCLOCK = 1'b0;
        check("t6_rst_count", 32'(COUNT), 32'd0);
        check("t6_rst_count_p", 32'(COUNT_P), 32'd0);
        check("t6_rst_busy", 32'(BUSY), 32'd0);
        check("t6_rst_pending", 32'(PENDING), 32'd0);
        hit(3'd2, 1'b1, 1'b0);
        check("t6_post_rst_hit", 32'(PENDING), 32'd2);
        START_GAME = 1'b1;
        tick();
        START_GAME = 1'b0;
        check("t6_start_pending", 32'(PENDING), 32'd0);
        check("t6_start_busy", 32'(BUSY), 32'd0);
        wait_n(2);

`ifdef POINTS_SEQUENCER_TOTAL_EN
        START_GAME = 1'b1;
        tick();
        START_GAME = 1'b0;
        tick();
        check("tot_clear", 32'(SCORE_TOTAL), 32'd0);
        for (int i = 0; i < 146; i++) begin
            hit(3'd7, 1'b0, 1'b0);
            push(7, 2'b01);
            run_strobes(1, 50);
        end
        wait_n(2);
        check("tot_p0_1022", 32'(SCORE_TOTAL[9:0]), 32'd1022);
        hit(3'd3, 1'b0, 1'b0);
        push(3, 2'b01);
        run_strobes(1, 20);
        wait_n(2);
        check("tot_p0_wrap", 32'(SCORE_TOTAL[9:0]), 32'd1);
        check("tot_p1_same", 32'(SCORE_TOTAL[19:10]), 32'd0);
`endif

        wait_n(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/points_sequencer.md
Name: points_sequencer

Overview:
- Parametrised successor to the two-player points counter.
- Converts brick-hit events carrying a point value into a train of single-cycle score pulses, paced by the score-clock strobe.
- Routes each train to one of NUM_PLAYERS score channels.
- Sits between the brick/ball hit logic and the per-player score display counters; hits arriving during a burst are accumulated instead of lost.

Parameters:
- NUM_PLAYERS, 2, number of player score channels (1..8).
- VALUE_W, 3, width of the per-hit point value.
- PEND_W, 6, width of the pending-points accumulator (saturating).
- HOLDOFF, 6, CLK_DRV cycles after an accepted hit during which further hit edges are ignored (one-shot emulation).

Ports:
- CLK_DRV  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START_GAME  in  1  synchronous clear of pending points and burst state (same effect as RESET; does not clear latched config).
- ATTRACT_N  in  1  low = attract mode; hits ignored, pending cleared, no pulses.
- BRICK_HIT  in  1  hit level; rising edge = hit event.
- HIT_VALUE  in  VALUE_W  points for the hit, sampled on the accepted edge cycle.
- PLAYER_SEL  in  $clog2(NUM_PLAYERS) (min 1)  current player index.
- SCLOCK  in  1  score-clock strobe, one CLK_DRV cycle wide.
- COUNT  out  1  one-cycle score pulse, any player.
- COUNT_P  out  NUM_PLAYERS  one-hot per-player pulse, equal to COUNT routed to the burst player.
- BUSY  out  1  high while pending points are nonzero.
- PENDING  out  PEND_W  current pending-points value.

Behaviour:
- Reset/START_GAME: COUNT=0, COUNT_P=0, BUSY=0, PENDING=0, holdoff=0, state IDLE, burst player=0, hit edge register=0.
- Edge detect: registered BRICK_HIT; event = BRICK_HIT & ~prev.
- Accept an event only if holdoff==0 and ATTRACT_N=1. On accept, load holdoff with HOLDOFF; it then decrements to 0.
- HIT_VALUE=0 is accepted (holdoff starts) but adds nothing.
- Accumulator: PENDING_next = PENDING + (accepted ? HIT_VALUE : 0) - (pulse ? 1 : 0), saturating at 2^PEND_W-1. Never underflows.
- Simultaneous hit and pulse in the same cycle: both applied, e.g. 3 + 4 - 1 = 6.
- Pulse: registered, so COUNT is high in the cycle after the SCLOCK strobe. A pulse occurs when SCLOCK=1, PENDING>0 and ATTRACT_N=1. A hit that arrives in the same cycle as SCLOCK does not produce a pulse in that cycle, because PENDING is still 0.
- State machine:
  - IDLE -> BURST when PENDING becomes nonzero. PLAYER_SEL is latched as the burst player on this transition only; later PLAYER_SEL changes do not reroute the current burst.
  - BURST -> IDLE on the cycle PENDING reaches 0.
  - A hit arriving during BURST extends the same burst for the same player.
- COUNT_P[burst player] = COUNT; all other bits 0. A PLAYER_SEL value >= NUM_PLAYERS latches as 0.
- ATTRACT_N low: PENDING forced to 0 next cycle, state IDLE, COUNT/COUNT_P held 0, holdoff cleared.
- BUSY = (PENDING != 0), registered with PENDING.

Optional Feature:
- Macro: POINTS_SEQUENCER_TOTAL_EN.
- Defined:
  - Adds output SCORE_TOTAL (NUM_PLAYERS*10 bits), one 10-bit binary total per player, player p at bits [10p+9:10p].
  - Each total increments on its COUNT_P bit and wraps 1023 -> 0.
  - Cleared by RESET/START_GAME; not cleared by ATTRACT_N.
- Undefined: port absent, no total registers; all other behaviour identical.

Test Plan:
- Reset then hit, HIT_VALUE=4, PLAYER_SEL=1, SCLOCK every 8 cycles -> PENDING=4 the cycle after the edge; exactly 4 COUNT pulses, each one cycle after a strobe; COUNT_P=2'b10 on each; BUSY falls with the 4th pulse.
- Second BRICK_HIT edge 3 cycles after the first (HOLDOFF=6) -> ignored. Edge at 7 cycles -> accepted, PENDING increases by HIT_VALUE.
- Hit value 3 while PENDING=5, SCLOCK strobe in the same cycle -> PENDING=7; burst continues uninterrupted for the original player even though PLAYER_SEL changes 1->0 mid-burst.
- PEND_W=4, PENDING=14 + hit of 7 -> PENDING saturates at 15; 15 pulses follow.
- ATTRACT_N dropped mid-burst with PENDING=3 -> no further pulses, PENDING=0, BUSY=0 next cycle. RESET asserted mid-burst -> all outputs 0 next cycle.
- With POINTS_SEQUENCER_TOTAL_EN: player 0 total preset to 1022 via 1022 pulses, then a hit of 3 -> total wraps to 1; player 1 total unchanged.
